// File: rtl/axi_rd_burst_split.sv
// Splits one upstream AXI read burst into a series of single-beat downstream reads.
// Bursts with a reserved type or an oversize beat are answered locally with SLVERR beats.
module axi_rd_burst_split #(
    parameter int TAGW = 1
) (
    input  logic            aclk,
    input  logic            rst,
    // upstream read address
    input  logic            s_arvalid,
    output logic            s_arready,
    input  logic [31:0]     s_araddr,
    input  logic [TAGW-1:0] s_arid,
    input  logic [7:0]      s_arlen,
    input  logic [1:0]      s_arburst,
    input  logic [2:0]      s_arsize,
    // upstream read data
    output logic            s_rvalid,
    input  logic            s_rready,
    output logic [63:0]     s_rdata,
    output logic [1:0]      s_rresp,
    output logic [TAGW-1:0] s_rid,
    output logic            s_rlast,
    // downstream read address
    output logic            m_arvalid,
    input  logic            m_arready,
    output logic [31:0]     m_araddr,
    output logic [TAGW-1:0] m_arid,
    output logic [7:0]      m_arlen,
    output logic [1:0]      m_arburst,
    output logic [2:0]      m_arsize,
    // downstream read data
    input  logic            m_rvalid,
    output logic            m_rready,
    input  logic [63:0]     m_rdata,
    input  logic [1:0]      m_rresp,
    input  logic [TAGW-1:0] m_rid,
    input  logic            m_rlast,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DATA  = 2'd2,
        ERR   = 2'd3
    } state_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    state_t          state, state_nxt;
    logic [31:0]     addr_q;
    logic [TAGW-1:0] id_q;
    logic [7:0]      len_q;
    logic [7:0]      cnt_q;
    logic [1:0]      burst_q;
    logic [2:0]      size_q;

    logic            ar_hs;
    logic            up_beat;
    logic            last_beat;
    logic            wrap_ok;
    logic [31:0]     step;
    logic [31:0]     wrap_mask;
    logic [31:0]     addr_nxt;

    assign ar_hs     = s_arvalid && s_arready;
    assign up_beat   = s_rvalid && s_rready;
    assign last_beat = (cnt_q == len_q);

    // Address of the next single-beat request.
    always_comb begin
        step      = 32'd1 << size_q;
        wrap_ok   = (len_q == 8'd1) || (len_q == 8'd3) || (len_q == 8'd7) || (len_q == 8'd15);
        wrap_mask = (({24'd0, len_q} + 32'd1) << size_q) - 32'd1;
        case (burst_q)
            BURST_FIXED: addr_nxt = addr_q;
            BURST_WRAP:  addr_nxt = wrap_ok ? ((addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask))
                                            : (addr_q + step);
            default:     addr_nxt = addr_q + step;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (ar_hs) state_nxt = ((s_arburst == BURST_RSVD) || (s_arsize > 3'd3)) ? ERR : ISSUE;
            ISSUE: if (m_arready) state_nxt = DATA;
            DATA:  if (up_beat) state_nxt = last_beat ? IDLE : ISSUE;
            ERR:   if (up_beat && last_beat) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: every output gets a default before the case so no path infers a latch.
    always_comb begin
        s_arready = 1'b0;
        s_rvalid  = 1'b0;
        s_rdata   = '0;
        s_rresp   = '0;
        s_rid     = '0;
        s_rlast   = 1'b0;
        m_arvalid = 1'b0;
        m_araddr  = '0;
        m_arid    = '0;
        m_arlen   = '0;
        m_arburst = '0;
        m_arsize  = '0;
        m_rready  = 1'b0;
        busy      = 1'b0;
        if (!rst) begin
            busy = (state != IDLE);
            case (state)
                IDLE: s_arready = 1'b1;
                ISSUE: begin
                    m_arvalid = 1'b1;
                    m_araddr  = addr_q;
                    m_arid    = id_q;
                    m_arburst = BURST_INCR;
                    m_arsize  = size_q;
                end
                DATA: begin
                    s_rvalid = m_rvalid;
                    m_rready = s_rready;
                    s_rdata  = m_rdata;
                    s_rresp  = m_rresp;
                    s_rid    = id_q;
                    s_rlast  = last_beat;
                end
                ERR: begin
                    s_rvalid = 1'b1;
                    s_rresp  = RESP_SLVERR;
                    s_rid    = id_q;
                    s_rlast  = last_beat;
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge aclk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            addr_q  <= '0;
            id_q    <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            burst_q <= '0;
            size_q  <= '0;
        end else begin
            case (state)
                IDLE: if (ar_hs) begin
                    addr_q  <= s_araddr;
                    id_q    <= s_arid;
                    len_q   <= s_arlen;
                    burst_q <= s_arburst;
                    size_q  <= s_arsize;
                    cnt_q   <= '0;
                end
                DATA: if (up_beat && !last_beat) begin
                    cnt_q  <= cnt_q + 8'd1;
                    addr_q <= addr_nxt;
                end
                ERR: if (up_beat && !last_beat) cnt_q <= cnt_q + 8'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rd_burst_split.sv
// Directed bench for axi_rd_burst_split: a zero-delay single-beat downstream slave,
// recorded handshakes, and hand-computed address/beat expectations per burst.
module tb_axi_rd_burst_split;

    localparam int TAGW = 1;

    logic            aclk = 1'b0;
    logic            rst  = 1'b1;
    logic            s_arvalid, s_arready;
    logic [31:0]     s_araddr;
    logic [TAGW-1:0] s_arid;
    logic [7:0]      s_arlen;
    logic [1:0]      s_arburst;
    logic [2:0]      s_arsize;
    logic            s_rvalid, s_rready;
    logic [63:0]     s_rdata;
    logic [1:0]      s_rresp;
    logic [TAGW-1:0] s_rid;
    logic            s_rlast;
    logic            m_arvalid, m_arready;
    logic [31:0]     m_araddr;
    logic [TAGW-1:0] m_arid;
    logic [7:0]      m_arlen;
    logic [1:0]      m_arburst;
    logic [2:0]      m_arsize;
    logic            m_rvalid, m_rready;
    logic [63:0]     m_rdata;
    logic [1:0]      m_rresp;
    logic [TAGW-1:0] m_rid;
    logic            m_rlast;
    logic            busy;

    always #5 aclk = ~aclk;

    axi_rd_burst_split #(.TAGW(TAGW)) dut (
        .aclk(aclk), .rst(rst),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
        .s_arlen(s_arlen), .s_arburst(s_arburst), .s_arsize(s_arsize),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_rid(s_rid), .s_rlast(s_rlast),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arid(m_arid),
        .m_arlen(m_arlen), .m_arburst(m_arburst), .m_arsize(m_arsize),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_rid(m_rid), .m_rlast(m_rlast),
        .busy(busy)
    );

    int n_checks = 0;
    int n_err    = 0;

    logic [31:0]     ar_q[$];
    logic [7:0]      arlen_q[$];
    logic [1:0]      arburst_q[$];
    logic [TAGW-1:0] arid_q[$];
    logic [63:0]     bd_q[$];
    logic [1:0]      br_q[$];
    logic [TAGW-1:0] bi_q[$];
    logic            bl_q[$];
    logic [31:0]     exp_q[$];

    logic [1:0] sl_resp = 2'b00;
    int         sl_n    = 0;
    logic       accepted;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: record handshakes seen before the edge, then update the downstream slave.
    task automatic tick();
        logic        ar_hs_s, r_hs_s;
        logic [31:0] a_s;
        #1;
        ar_hs_s = m_arvalid && m_arready;
        r_hs_s  = m_rvalid && m_rready;
        a_s     = m_araddr;
        if (s_arvalid && s_arready) accepted = 1'b1;
        if (ar_hs_s) begin
            ar_q.push_back(m_araddr);
            arlen_q.push_back(m_arlen);
            arburst_q.push_back(m_arburst);
            arid_q.push_back(m_arid);
        end
        if (s_rvalid && s_rready) begin
            bd_q.push_back(s_rdata);
            br_q.push_back(s_rresp);
            bi_q.push_back(s_rid);
            bl_q.push_back(s_rlast);
        end
        @(posedge aclk);
        @(negedge aclk);
        if (r_hs_s) m_rvalid = 1'b0;
        if (ar_hs_s) begin
            m_rvalid = 1'b1;
            m_rdata  = {16'hCAFE, 16'(sl_n), a_s};
            m_rresp  = sl_resp;
            sl_n++;
        end
    endtask

    task automatic clear_q();
        ar_q.delete(); arlen_q.delete(); arburst_q.delete(); arid_q.delete();
        bd_q.delete(); br_q.delete(); bi_q.delete(); bl_q.delete();
        sl_n = 0;
    endtask

    task automatic start_ar(input string tag, input logic [31:0] a, input logic [TAGW-1:0] id,
                            input logic [7:0] len, input logic [1:0] bt, input logic [2:0] sz);
        s_arvalid = 1'b1; s_araddr = a; s_arid = id; s_arlen = len; s_arburst = bt; s_arsize = sz;
        accepted  = 1'b0;
        #1;
        check({tag, ":idle_arready"}, s_arready, 1);
        check({tag, ":idle_arvalid"}, m_arvalid, 0);
        check({tag, ":idle_rvalid"}, s_rvalid, 0);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (accepted) break;
        end
        s_arvalid = 1'b0;
        check({tag, ":accepted"}, accepted, 1);
    endtask

    task automatic wait_last(input string tag);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (bl_q.size() > 0 && bl_q[bl_q.size()-1]) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        check({tag, ":completed"}, done, 1);
        #1;
        check({tag, ":busy_after"}, busy, 0);
    endtask

    task automatic check_burst(input string tag, input int nb, input logic is_err,
                               input logic [1:0] resp, input logic [TAGW-1:0] id);
        check({tag, ":ar_count"}, ar_q.size(), exp_q.size());
        for (int i = 0; i < ar_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s:araddr%0d", tag, i), ar_q[i], exp_q[i]);
            check($sformatf("%s:arlen%0d", tag, i), arlen_q[i], 0);
            check($sformatf("%s:arburst%0d", tag, i), arburst_q[i], 1);
            check($sformatf("%s:arid%0d", tag, i), arid_q[i], id);
        end
        check({tag, ":beat_count"}, bd_q.size(), nb);
        for (int i = 0; i < bd_q.size() && i < nb; i++) begin
            check($sformatf("%s:rlast%0d", tag, i), bl_q[i], (i == nb - 1));
            check($sformatf("%s:rid%0d", tag, i), bi_q[i], id);
            check($sformatf("%s:rresp%0d", tag, i), br_q[i], resp);
            if (is_err)
                check($sformatf("%s:rdata%0d", tag, i), bd_q[i], 0);
            else if (i < exp_q.size())
                check($sformatf("%s:rdata%0d", tag, i), bd_q[i], {16'hCAFE, 16'(i), exp_q[i]});
        end
    endtask

    initial begin
        s_arvalid = 0; s_araddr = 0; s_arid = 0; s_arlen = 0; s_arburst = 0; s_arsize = 0;
        s_rready  = 1; m_arready = 1; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
        m_rid     = 1'b0; m_rlast = 1'b1;
        @(negedge aclk);
        repeat (2) tick();
        #1;
        check("reset:arready", s_arready, 0);
        check("reset:rvalid", s_rvalid, 0);
        check("reset:arvalid", m_arvalid, 0);
        check("reset:rready", m_rready, 0);
        check("reset:busy", busy, 0);
        check("reset:rlast", s_rlast, 0);
        check("reset:araddr", m_araddr, 0);
        rst = 1'b0;
        #1;
        check("reset:arready_after", s_arready, 1);

        clear_q();
        start_ar("incr", 32'h1000, 1'b1, 8'd3, 2'b01, 3'd3);
        wait_last("incr");
        exp_q = '{32'h1000, 32'h1008, 32'h1010, 32'h1018};
        check_burst("incr", 4, 1'b0, 2'b00, 1'b1);

        clear_q();
        start_ar("wrap", 32'h2018, 1'b1, 8'd3, 2'b10, 3'd3);
        wait_last("wrap");
        exp_q = '{32'h2018, 32'h2000, 32'h2008, 32'h2010};
        check_burst("wrap", 4, 1'b0, 2'b00, 1'b1);

        clear_q();
        start_ar("wrap_len2", 32'h2018, 1'b0, 8'd2, 2'b10, 3'd3);
        wait_last("wrap_len2");
        exp_q = '{32'h2018, 32'h2020, 32'h2028};
        check_burst("wrap_len2", 3, 1'b0, 2'b00, 1'b0);

        clear_q();
        start_ar("rsvd", 32'h3000, 1'b1, 8'd2, 2'b11, 3'd3);
        wait_last("rsvd");
        exp_q.delete();
        check_burst("rsvd", 3, 1'b1, 2'b10, 1'b1);

        clear_q();
        start_ar("size4", 32'h3100, 1'b1, 8'd0, 2'b01, 3'd4);
        wait_last("size4");
        exp_q.delete();
        check_burst("size4", 1, 1'b1, 2'b10, 1'b1);

        // Upstream holds off beat 0; nothing downstream may move meanwhile.
        clear_q();
        s_rready = 1'b0;
        start_ar("bp", 32'h100, 1'b1, 8'd1, 2'b01, 3'd3);
        for (int i = 0; i < 20; i++) begin
            #1;
            if (s_rvalid) break;
            tick();
        end
        check("bp:rvalid_seen", s_rvalid, 1);
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("bp:rready_low%0d", i), m_rready, 0);
            check($sformatf("bp:rdata_stable%0d", i), s_rdata, {16'hCAFE, 16'd0, 32'h100});
            check($sformatf("bp:no_arvalid%0d", i), m_arvalid, 0);
            check($sformatf("bp:rlast%0d", i), s_rlast, 0);
            tick();
        end
        check("bp:ar_before_release", ar_q.size(), 1);
        s_rready = 1'b1;
        wait_last("bp");
        exp_q = '{32'h100, 32'h108};
        check_burst("bp", 2, 1'b0, 2'b00, 1'b1);

        clear_q();
        start_ar("fixed", 32'h30, 1'b1, 8'd2, 2'b00, 3'd2);
        wait_last("fixed");
        exp_q = '{32'h30, 32'h30, 32'h30};
        check_burst("fixed", 3, 1'b0, 2'b00, 1'b1);

        clear_q();
        start_ar("wrap32", 32'hFFFF_FFF8, 1'b1, 8'd1, 2'b01, 3'd3);
        wait_last("wrap32");
        exp_q = '{32'hFFFF_FFF8, 32'h0000_0000};
        check_burst("wrap32", 2, 1'b0, 2'b00, 1'b1);

        clear_q();
        sl_resp = 2'b11;
        start_ar("decerr", 32'h600, 1'b1, 8'd1, 2'b01, 3'd2);
        wait_last("decerr");
        exp_q = '{32'h600, 32'h604};
        check_burst("decerr", 2, 1'b0, 2'b11, 1'b1);
        sl_resp = 2'b00;

        // Reset while beat 2 of an 8-beat burst is on the bus.
        clear_q();
        start_ar("rst_mid", 32'h4000, 1'b1, 8'd7, 2'b01, 3'd3);
        for (int i = 0; i < 100; i++) begin
            #1;
            if (bd_q.size() == 2 && s_rvalid) break;
            tick();
        end
        check("rst_mid:at_beat2", bd_q.size(), 2);
        rst = 1'b1;
        tick();
        #1;
        check("rst_mid:arready_in_rst", s_arready, 0);
        check("rst_mid:rvalid", s_rvalid, 0);
        check("rst_mid:arvalid", m_arvalid, 0);
        check("rst_mid:busy", busy, 0);
        rst = 1'b0;
        #1;
        check("rst_mid:arready_after", s_arready, 1);
        check("rst_mid:rvalid_after", s_rvalid, 0);
        check("rst_mid:rready_stray", m_rready, 0);
        tick();
        check("rst_mid:no_more_beats", bd_q.size(), 2);
        m_rvalid = 1'b0;
        clear_q();
        start_ar("post_rst", 32'h5000, 1'b1, 8'd1, 2'b01, 3'd3);
        wait_last("post_rst");
        exp_q = '{32'h5000, 32'h5008};
        check_burst("post_rst", 2, 1'b0, 2'b00, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
